// File: rtl/draw_layer_scheduler.sv
// ============================================================================
// draw_layer_scheduler
// ----------------------------------------------------------------------------
// Per-pixel layer arbiter between the VGA background generator and the sprite
// draw blocks. Picks one RRRGGGBB colour per pixel by fixed priority
// (player > rope > ball > background) and registers it. It also detects
// player/ball overlap once per frame and runs a frame-counted background
// flash when hit events arrive.
//
// Parameters:
//   FLASH_FRAMES  number of whole frames the background is replaced (1..15)
//   FLASH_COLOR   colour substituted for BG_RGB while flashing
//
// Ports:
//   clk            pixel clock
//   resetN         synchronous active-low reset
//   startOfFrame   one-clk pulse on the first pixel of each frame
//   BG_RGB         background pixel colour
//   playerDrawReq  player covers the pixel      / playerRGB  its colour
//   ropeDrawReq    rope covers the pixel        / ropeRGB    its colour
//   ballDrawReq    ball covers the pixel        / ballRGB    its colour
//   layerEnable    {player, rope, ball} enables, sampled at frame start only
//   flashTrig      hit event requesting a flash
//   RGBOut         registered selected colour (1 clk after inputs)
//   flashActive    high while the flash is being displayed
//   colPlayerBall  one-clk pulse at frame start: player/ball overlapped last frame
//   colRopeBall    same for rope/ball when ROPE_COLLISION_EN is defined, else 0
//
// Optional feature macro: ROPE_COLLISION_EN (adds rope/ball overlap detection).
// ============================================================================
module draw_layer_scheduler #(
   parameter int         FLASH_FRAMES = 4,
   parameter logic [7:0] FLASH_COLOR  = 8'hE0
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic [7:0] BG_RGB,
   input  logic       playerDrawReq,
   input  logic [7:0] playerRGB,
   input  logic       ropeDrawReq,
   input  logic [7:0] ropeRGB,
   input  logic       ballDrawReq,
   input  logic [7:0] ballRGB,
   input  logic [2:0] layerEnable,
   input  logic       flashTrig,
   output logic [7:0] RGBOut,
   output logic       flashActive,
   output logic       colPlayerBall,
   output logic       colRopeBall
);

   typedef enum logic {
      IDLE,
      FLASH
   } flash_state_t;

   localparam logic [3:0] FLASH_LOAD = 4'(FLASH_FRAMES);

   flash_state_t state;
   logic [3:0]   count;
   logic         pending;
   logic [2:0]   shadow;
   logic [2:0]   layer_en;
   logic         retrig;
   logic         last_frame;
   logic         flash_now;
   logic [7:0]   bg_src;
   logic [7:0]   pixel_next;
   logic         pb_hit;
   logic         pb_flag;

   // The enables in force for the current pixel. On the frame-start cycle the
   // freshly sampled layerEnable already applies, so the whole new frame,
   // including its first pixel, uses the new value.
   assign layer_en = startOfFrame ? layerEnable : shadow;

   // Shadow copy of the layer enables, only reloaded at frame boundaries so a
   // mid-frame change cannot tear the picture.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         shadow <= 3'b111;
      end else if (startOfFrame) begin
         shadow <= layerEnable;
      end
   end

   // A trigger seen in the frame-start cycle counts just like one that was
   // already pending, so it is never lost between frames.
   assign retrig     = pending | flashTrig;
   assign last_frame = (count <= 4'd1);

   // Whether the pixel currently being selected belongs to a flashed frame.
   // This is the state the FSM will hold after this edge, so the frame-start
   // pixel is coloured consistently with the rest of its frame and RGBOut
   // lines up with flashActive.
   always_comb begin
      flash_now = (state == FLASH);
      if (startOfFrame) begin
         if (state == IDLE) begin
            flash_now = retrig;
         end else if (last_frame && !retrig) begin
            flash_now = 1'b0;
         end
      end
   end

   // Flash sequencer. Entering FLASH loads the frame counter; each later frame
   // start counts down, and the frame start that finds the counter at 1 either
   // leaves FLASH or, if another hit arrived meanwhile, starts a fresh flash
   // back to back. Hits during a flash are only remembered, never extend it.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state       <= IDLE;
         count       <= 4'd0;
         pending     <= 1'b0;
         flashActive <= 1'b0;
      end else begin
         flashActive <= flash_now;
         pending     <= retrig;
         if (startOfFrame) begin
            case (state)
               IDLE: begin
                  if (retrig) begin
                     state   <= FLASH;
                     count   <= FLASH_LOAD;
                     pending <= 1'b0;
                  end
               end
               FLASH: begin
                  if (!last_frame) begin
                     count <= count - 4'd1;
                  end else if (retrig) begin
                     count   <= FLASH_LOAD;
                     pending <= 1'b0;
                  end else begin
                     state <= IDLE;
                     count <= 4'd0;
                  end
               end
               default: begin
                  state <= IDLE;
                  count <= 4'd0;
               end
            endcase
         end
      end
   end

   // Fixed-priority layer selection; a layer only wins when it is both
   // requesting and enabled, otherwise the (possibly flashed) background shows.
   assign bg_src = flash_now ? FLASH_COLOR : BG_RGB;

   always_comb begin
      pixel_next = bg_src;
      if (playerDrawReq && layer_en[2]) begin
         pixel_next = playerRGB;
      end else if (ropeDrawReq && layer_en[1]) begin
         pixel_next = ropeRGB;
      end else if (ballDrawReq && layer_en[0]) begin
         pixel_next = ballRGB;
      end
   end

   // Output pixel register: one clock of latency, no combinational path.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         RGBOut <= 8'h00;
      end else begin
         RGBOut <= pixel_next;
      end
   end

   // Player/ball overlap accumulates over a frame. At frame start the result
   // of the finished frame is emitted as a single-cycle pulse, and the flag
   // restarts with whatever overlap exists on that first pixel.
   assign pb_hit = playerDrawReq & ballDrawReq & layer_en[2] & layer_en[0];

   always_ff @(posedge clk) begin
      if (!resetN) begin
         pb_flag       <= 1'b0;
         colPlayerBall <= 1'b0;
      end else if (startOfFrame) begin
         colPlayerBall <= pb_flag;
         pb_flag       <= pb_hit;
      end else begin
         colPlayerBall <= 1'b0;
         pb_flag       <= pb_flag | pb_hit;
      end
   end

`ifdef ROPE_COLLISION_EN
   logic rb_hit;
   logic rb_flag;

   assign rb_hit = ropeDrawReq & ballDrawReq & layer_en[1] & layer_en[0];

   // Rope/ball overlap, with exactly the same per-frame pulse timing as the
   // player/ball detector.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         rb_flag     <= 1'b0;
         colRopeBall <= 1'b0;
      end else if (startOfFrame) begin
         colRopeBall <= rb_flag;
         rb_flag     <= rb_hit;
      end else begin
         colRopeBall <= 1'b0;
         rb_flag     <= rb_flag | rb_hit;
      end
   end
`else
   assign colRopeBall = 1'b0;
`endif

endmodule

// File: tb/tb_draw_layer_scheduler.sv
// ============================================================================
// tb_draw_layer_scheduler
// ----------------------------------------------------------------------------
// Self-checking bench for draw_layer_scheduler: a vector table for the pixel
// priority, hand-written sequences for shadowing, flash, collision and reset,
// then randomized frames compared against a frame-level reference model.
// ============================================================================
module tb_draw_layer_scheduler;

   localparam int         FLASH_FRAMES = 4;
   localparam logic [7:0] FLASH_COLOR  = 8'hE0;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic [7:0] BG_RGB;
   logic       playerDrawReq;
   logic [7:0] playerRGB;
   logic       ropeDrawReq;
   logic [7:0] ropeRGB;
   logic       ballDrawReq;
   logic [7:0] ballRGB;
   logic [2:0] layerEnable;
   logic       flashTrig;
   logic [7:0] RGBOut;
   logic       flashActive;
   logic       colPlayerBall;
   logic       colRopeBall;

   int compared   = 0;
   int mismatched = 0;

   logic [2:0] curEn;

   // Reference model state, kept in frame-level terms.
   logic [2:0] mShadow;
   int         mFramesLeft;
   logic       mPending;
   logic       mPbSeen;
   logic       mRbSeen;
   logic [7:0] expRgb;
   logic       expFlash;
   logic       expColPb;
   logic       expColRb;

   typedef struct {
      logic [2:0] en;
      logic [2:0] req;
      logic [7:0] rgb;
   } vecT;

   vecT vecs[7];

   always #5 clk = ~clk;

   draw_layer_scheduler #(
      .FLASH_FRAMES(FLASH_FRAMES),
      .FLASH_COLOR (FLASH_COLOR)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .BG_RGB       (BG_RGB),
      .playerDrawReq(playerDrawReq),
      .playerRGB    (playerRGB),
      .ropeDrawReq  (ropeDrawReq),
      .ropeRGB      (ropeRGB),
      .ballDrawReq  (ballDrawReq),
      .ballRGB      (ballRGB),
      .layerEnable  (layerEnable),
      .flashTrig    (flashTrig),
      .RGBOut       (RGBOut),
      .flashActive  (flashActive),
      .colPlayerBall(colPlayerBall),
      .colRopeBall  (colRopeBall)
   );

   // Advances the reference model by one pixel using the inputs now driven.
   // The flash is tracked as "frames still to show" plus a remembered hit.
   task automatic modelStep();
      logic [2:0] en;
      logic       pb;
      logic       rb;
      if (!resetN) begin
         mShadow     = 3'b111;
         mFramesLeft = 0;
         mPending    = 1'b0;
         mPbSeen     = 1'b0;
         mRbSeen     = 1'b0;
         expRgb      = 8'h00;
         expFlash    = 1'b0;
         expColPb    = 1'b0;
         expColRb    = 1'b0;
      end else begin
         en = startOfFrame ? layerEnable : mShadow;
         if (startOfFrame) begin
            mShadow = layerEnable;
            if (mFramesLeft > 1) begin
               mFramesLeft = mFramesLeft - 1;
               mPending    = mPending || flashTrig;
            end else if (mPending || flashTrig) begin
               mFramesLeft = FLASH_FRAMES;
               mPending    = 1'b0;
            end else begin
               mFramesLeft = 0;
            end
         end else begin
            mPending = mPending || flashTrig;
         end
         expFlash = (mFramesLeft > 0);
         if (playerDrawReq && en[2])     expRgb = playerRGB;
         else if (ropeDrawReq && en[1])  expRgb = ropeRGB;
         else if (ballDrawReq && en[0])  expRgb = ballRGB;
         else                            expRgb = expFlash ? FLASH_COLOR : BG_RGB;
         pb = playerDrawReq && ballDrawReq && en[2] && en[0];
         rb = ropeDrawReq && ballDrawReq && en[1] && en[0];
         if (startOfFrame) begin
            expColPb = mPbSeen;
            mPbSeen  = pb;
            expColRb = mRbSeen;
            mRbSeen  = rb;
         end else begin
            expColPb = 1'b0;
            mPbSeen  = mPbSeen || pb;
            expColRb = 1'b0;
            mRbSeen  = mRbSeen || rb;
         end
`ifndef ROPE_COLLISION_EN
         expColRb = 1'b0;
`endif
      end
   endtask

   // Drives one pixel's inputs, steps the model and waits until just after
   // the clock edge that registers them.
   task automatic applyStimulus(input logic rst, input logic sof, input logic [2:0] en,
                                input logic [2:0] req, input logic [7:0] bg, input logic trig);
      resetN        = rst;
      startOfFrame  = sof;
      layerEnable   = en;
      playerDrawReq = req[2];
      ropeDrawReq   = req[1];
      ballDrawReq   = req[0];
      BG_RGB        = bg;
      flashTrig     = trig;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".rgb"},   RGBOut,              expRgb);
      checkOutput({tag, ".flash"}, {7'd0, flashActive}, {7'd0, expFlash});
      checkOutput({tag, ".colPB"}, {7'd0, colPlayerBall}, {7'd0, expColPb});
      checkOutput({tag, ".colRB"}, {7'd0, colRopeBall},   {7'd0, expColRb});
   endtask

   task automatic step(input logic sof, input logic [2:0] req, input logic trig);
      applyStimulus(1'b1, sof, curEn, req, 8'h5A, trig);
      checkModel("seq");
   endtask

   initial begin
      logic rbExp;
      resetN = 1'b0; startOfFrame = 1'b0; BG_RGB = 8'h5A; layerEnable = 3'b111;
      playerDrawReq = 1'b0; ropeDrawReq = 1'b0; ballDrawReq = 1'b0; flashTrig = 1'b0;
      playerRGB = 8'h1C; ropeRGB = 8'h03; ballRGB = 8'hE3;
      curEn = 3'b111;

      vecs[0] = '{en: 3'b111, req: 3'b111, rgb: 8'h1C};
      vecs[1] = '{en: 3'b111, req: 3'b011, rgb: 8'h03};
      vecs[2] = '{en: 3'b111, req: 3'b001, rgb: 8'hE3};
      vecs[3] = '{en: 3'b111, req: 3'b000, rgb: 8'h5A};
      vecs[4] = '{en: 3'b111, req: 3'b101, rgb: 8'h1C};
      vecs[5] = '{en: 3'b111, req: 3'b010, rgb: 8'h03};
      vecs[6] = '{en: 3'b011, req: 3'b100, rgb: 8'h1C};

      $display("[TB] reset");
      applyStimulus(1'b0, 1'b0, 3'b111, 3'b111, 8'h5A, 1'b1);
      applyStimulus(1'b0, 1'b1, 3'b111, 3'b111, 8'h5A, 1'b1);
      checkOutput("reset.rgb",   RGBOut, 8'h00);
      checkOutput("reset.flash", {7'd0, flashActive},   8'h00);
      checkOutput("reset.colPB", {7'd0, colPlayerBall}, 8'h00);
      checkOutput("reset.colRB", {7'd0, colRopeBall},   8'h00);

      $display("[TB] priority table");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 1'b0, vecs[i].en, vecs[i].req, 8'h5A, 1'b0);
         checkOutput($sformatf("vec%0d.rgb", i), RGBOut, vecs[i].rgb);
         checkModel($sformatf("vec%0d", i));
      end

      $display("[TB] layer shadow");
      curEn = 3'b011;
      step(1'b1, 3'b100, 1'b0);
      checkOutput("shadow.sofBg", RGBOut, 8'h5A);
      checkOutput("shadow.tablePulse", {7'd0, colPlayerBall}, 8'h01);
      step(1'b0, 3'b100, 1'b0);
      checkOutput("shadow.playerOff", RGBOut, 8'h5A);
      step(1'b0, 3'b110, 1'b0);
      checkOutput("shadow.ropeShows", RGBOut, 8'h03);
      curEn = 3'b111;
      step(1'b0, 3'b100, 1'b0);
      checkOutput("shadow.midFrameIgnored", RGBOut, 8'h5A);
      step(1'b1, 3'b100, 1'b0);
      checkOutput("shadow.newFrame", RGBOut, 8'h1C);

      $display("[TB] player/ball collision");
      for (int i = 0; i < 3; i++) step(1'b0, 3'b101, 1'b0);
      step(1'b0, 3'b000, 1'b0);
      step(1'b1, 3'b000, 1'b0);
      checkOutput("col.pulseN1", {7'd0, colPlayerBall}, 8'h01);
      step(1'b0, 3'b000, 1'b0);
      checkOutput("col.pulseWidth", {7'd0, colPlayerBall}, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 1'b0);
      step(1'b1, 3'b000, 1'b0);
      checkOutput("col.noPulseN2", {7'd0, colPlayerBall}, 8'h00);
      curEn = 3'b110;
      step(1'b1, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 3'b101, 1'b0);
      checkOutput("col.disabledDraw", RGBOut, 8'h1C);
      step(1'b1, 3'b000, 1'b0);
      checkOutput("col.disabledNoPulse", {7'd0, colPlayerBall}, 8'h00);

      $display("[TB] rope/ball collision");
      curEn = 3'b111;
      step(1'b1, 3'b000, 1'b0);
      step(1'b0, 3'b011, 1'b0);
      checkOutput("rope.rgb", RGBOut, 8'h03);
      step(1'b0, 3'b011, 1'b0);
      step(1'b0, 3'b000, 1'b0);
      step(1'b1, 3'b000, 1'b0);
`ifdef ROPE_COLLISION_EN
      rbExp = 1'b1;
`else
      rbExp = 1'b0;
`endif
      checkOutput("rope.pulse", {7'd0, colRopeBall}, {7'd0, rbExp});
      checkOutput("rope.noPbPulse", {7'd0, colPlayerBall}, 8'h00);
      step(1'b0, 3'b000, 1'b0);
      checkOutput("rope.pulseWidth", {7'd0, colRopeBall}, 8'h00);

      $display("[TB] flash");
      step(1'b0, 3'b000, 1'b1);
      step(1'b0, 3'b000, 1'b0);
      checkOutput("flash.notYet", {7'd0, flashActive}, 8'h00);
      for (int f = 1; f <= 4; f++) begin
         step(1'b1, 3'b000, 1'b0);
         checkOutput($sformatf("flash.f%0d.active", f), {7'd0, flashActive}, 8'h01);
         checkOutput($sformatf("flash.f%0d.sofBg", f), RGBOut, 8'hE0);
         step(1'b0, 3'b100, 1'b0);
         checkOutput($sformatf("flash.f%0d.sprite", f), RGBOut, 8'h1C);
         step(1'b0, 3'b000, 1'b0);
         checkOutput($sformatf("flash.f%0d.bg", f), RGBOut, 8'hE0);
      end
      step(1'b1, 3'b000, 1'b0);
      checkOutput("flash.end.active", {7'd0, flashActive}, 8'h00);
      checkOutput("flash.end.bg", RGBOut, 8'h5A);

      $display("[TB] flash retrigger");
      step(1'b0, 3'b000, 1'b1);
      for (int f = 1; f <= 8; f++) begin
         step(1'b1, 3'b000, 1'b0);
         checkOutput($sformatf("retrig.f%0d.active", f), {7'd0, flashActive}, 8'h01);
         step(1'b0, 3'b000, f == 2);
         step(1'b0, 3'b000, 1'b0);
      end
      step(1'b1, 3'b000, 1'b0);
      checkOutput("retrig.end", {7'd0, flashActive}, 8'h00);

      $display("[TB] reset mid-flash");
      step(1'b0, 3'b000, 1'b1);
      step(1'b1, 3'b000, 1'b0);
      step(1'b0, 3'b000, 1'b0);
      step(1'b1, 3'b000, 1'b0);
      checkOutput("rstflash.frame2", {7'd0, flashActive}, 8'h01);
      step(1'b0, 3'b101, 1'b0);
      applyStimulus(1'b0, 1'b0, curEn, 3'b101, 8'h5A, 1'b0);
      checkModel("rst");
      checkOutput("rstflash.rgb",   RGBOut, 8'h00);
      checkOutput("rstflash.flash", {7'd0, flashActive}, 8'h00);
      curEn = 3'b000;
      step(1'b0, 3'b100, 1'b0);
      checkOutput("rstflash.shadow", RGBOut, 8'h1C);
      curEn = 3'b111;
      step(1'b0, 3'b000, 1'b0);
      step(1'b1, 3'b000, 1'b0);
      checkOutput("rstflash.noPulse", {7'd0, colPlayerBall}, 8'h00);
      checkOutput("rstflash.stillIdle", {7'd0, flashActive}, 8'h00);

      $display("[TB] random frames");
      for (int f = 0; f < 120; f++) begin
         int len;
         len = $urandom_range(3, 12);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 3) == 0) curEn = 3'($urandom);
            playerRGB = 8'($urandom);
            ropeRGB   = 8'($urandom);
            ballRGB   = 8'($urandom);
            applyStimulus($urandom_range(0, 199) != 0, c == 0, curEn, 3'($urandom),
                          8'($urandom), $urandom_range(0, 9) == 0);
            checkModel("rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
